mem_rmw_ctrl: RTL and testbench

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

---
 rtl/rmw_pkg.sv | 17 +
 rtl/mem_rmw_ctrl_if.sv | 32 +++
 rtl/rmw_lat_cnt.sv | 31 +++
 rtl/mem_rmw_ctrl.sv | 99 +++++++++
 tb/tb_mem_rmw_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rmw_pkg.sv
// Shared types for the read-modify-write memory controller.
package rmw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        MERGE,
        WR,
        DONE
    } state_e;

    localparam logic [1:0] BMT_D = 2'b00;
    localparam logic [1:0] BMT_W = 2'b01;
    localparam logic [1:0] BMT_H = 2'b10;
    localparam logic [1:0] BMT_B = 2'b11;

endpackage

// File: rtl/mem_rmw_ctrl_if.sv
// Request, memory, store-merge and completion signals of the RMW controller.
interface mem_rmw_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bmt;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [1:0]  merge_bmt;
    logic [63:0] merge_in;
    logic [63:0] merge_read;
    logic [63:0] merge_out;
    logic        done_valid;
    logic [63:0] done_rdata;

    modport slave (
        input  req_valid, req_we, req_bmt, req_addr, req_wdata, mem_rdata, merge_out,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
               merge_bmt, merge_in, merge_read, done_valid, done_rdata
    );

    modport master (
        output req_valid, req_we, req_bmt, req_addr, req_wdata, mem_rdata, merge_out,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
               merge_bmt, merge_in, merge_read, done_valid, done_rdata
    );
endinterface

// File: rtl/rmw_lat_cnt.sv
// Read-wait counter: done is high on the MEM_LAT-th cycle after load.
module rmw_lat_cnt #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en && !done)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == LAST);
endmodule

// File: rtl/mem_rmw_ctrl.sv
// Memory access controller: loads, full stores, and read-modify-write for
// partial stores with the merge performed by an external stage.
module mem_rmw_ctrl
    import rmw_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_rmw_ctrl_if.slave  bus
);
    state_e      state_q, state_d;
    logic        we_q;
    logic [1:0]  bmt_q;
    logic [63:0] addr_q, wdata_q, rdata_q, merged_q;
    logic        accept, cnt_done;

    assign accept = (state_q == IDLE) && bus.req_valid;

    rmw_lat_cnt #(.MEM_LAT(MEM_LAT)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (state_q == RD_WAIT),
        .done  (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid)
                         state_d = (bus.req_we && bus.req_bmt == BMT_D) ? WR : RD_WAIT;
            RD_WAIT: if (cnt_done) state_d = we_q ? MERGE : DONE;
            MERGE:   state_d = WR;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every datapath output is zero outside the state that owns it.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.merge_bmt  = '0;
        bus.merge_in   = '0;
        bus.merge_read = '0;
        bus.done_valid = 1'b0;
        bus.done_rdata = '0;
        case (state_q)
            RD_WAIT: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = addr_q;
            end
            MERGE: begin
                bus.merge_bmt  = bmt_q;
                bus.merge_in   = wdata_q;
                bus.merge_read = rdata_q;
            end
            WR: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = (bmt_q == BMT_D) ? wdata_q : merged_q;
            end
            DONE: begin
                bus.done_valid = 1'b1;
                bus.done_rdata = we_q ? 64'd0 : rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            bmt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                bmt_q   <= bus.req_bmt;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == RD_WAIT && cnt_done)
                rdata_q <= bus.mem_rdata;
            if (state_q == MERGE)
                merged_q <= bus.merge_out;
        end
    end
endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Directed bench for mem_rmw_ctrl with read latencies of 1 and 3 cycles.
module tb_mem_rmw_ctrl;
    import rmw_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_rmw_ctrl_if b1 ();
    mem_rmw_ctrl_if b3 ();

    mem_rmw_ctrl #(.MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    mem_rmw_ctrl #(.MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    // Downstream store-merge stage: replace the low bytes of the read doubleword.
    function automatic logic [63:0] merge_model(input logic [1:0] bmt,
                                                input logic [63:0] din,
                                                input logic [63:0] rd);
        case (bmt)
            BMT_W:   return {rd[63:32], din[31:0]};
            BMT_H:   return {rd[63:16], din[15:0]};
            BMT_B:   return {rd[63:8],  din[7:0]};
            default: return din;
        endcase
    endfunction

    assign b1.merge_out = merge_model(b1.merge_bmt, b1.merge_in, b1.merge_read);
    assign b3.merge_out = merge_model(b3.merge_bmt, b3.merge_in, b3.merge_read);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        chkb("no_overlap_l1", b1.mem_rd & b1.mem_wr, 1'b0);
        chkb("no_overlap_l3", b3.mem_rd & b3.mem_wr, 1'b0);
    endtask

    task automatic req1(input logic we, input logic [1:0] bmt,
                        input logic [63:0] addr, input logic [63:0] wdata);
        b1.req_valid = 1'b1;
        b1.req_we    = we;
        b1.req_bmt   = bmt;
        b1.req_addr  = addr;
        b1.req_wdata = wdata;
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_bmt = '0;
        b1.req_addr = '0; b1.req_wdata = '0; b1.mem_rdata = '0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_bmt = '0;
        b3.req_addr = '0; b3.req_wdata = '0; b3.mem_rdata = '0;

        // Reset state
        step();
        chkb("rst_ready", b1.req_ready, 1'b1);
        chkb("rst_rd", b1.mem_rd, 1'b0);
        chkb("rst_wr", b1.mem_wr, 1'b0);
        chkb("rst_done", b1.done_valid, 1'b0);
        chk ("rst_addr", b1.mem_addr, 64'd0);
        chkb("rst_ready_l3", b3.req_ready, 1'b1);
        step();
        reset = 1'b0;
        step();

        // sd: write at T+1, done at T+2, no read
        req1(1'b1, BMT_D, 64'h40, 64'h1122334455667788);
        chkb("sd_ready", b1.req_ready, 1'b1);
        step();
        b1.req_valid = 1'b0;
        chkb("sd_wr", b1.mem_wr, 1'b1);
        chkb("sd_rd", b1.mem_rd, 1'b0);
        chk ("sd_addr", b1.mem_addr, 64'h40);
        chk ("sd_wdata", b1.mem_wdata, 64'h1122334455667788);
        chkb("sd_busy", b1.req_ready, 1'b0);
        step();
        chkb("sd_done", b1.done_valid, 1'b1);
        chk ("sd_done_rdata", b1.done_rdata, 64'd0);
        chkb("sd_wr_off", b1.mem_wr, 1'b0);
        step();
        chkb("sd_idle", b1.req_ready, 1'b1);
        chkb("sd_done_off", b1.done_valid, 1'b0);

        // sb, MEM_LAT=1: done at T+4
        b1.mem_rdata = 64'hAAAAAAAAAAAAAAAA;
        req1(1'b1, BMT_B, 64'h80, 64'hFF);
        step();
        b1.req_valid = 1'b0;
        chkb("sb_rd", b1.mem_rd, 1'b1);
        chk ("sb_rd_addr", b1.mem_addr, 64'h80);
        step();
        chk ("sb_merge_read", b1.merge_read, 64'hAAAAAAAAAAAAAAAA);
        chk ("sb_merge_in", b1.merge_in, 64'hFF);
        chk ("sb_merge_bmt", 64'(b1.merge_bmt), 64'd3);
        chkb("sb_rd_off", b1.mem_rd, 1'b0);
        step();
        chkb("sb_wr", b1.mem_wr, 1'b1);
        chk ("sb_wdata", b1.mem_wdata, 64'hAAAAAAAAAAAAAAFF);
        chk ("sb_merge_idle", b1.merge_read, 64'd0);
        step();
        chkb("sb_done", b1.done_valid, 1'b1);
        chk ("sb_done_rdata", b1.done_rdata, 64'd0);
        step();
        chkb("sb_idle", b1.req_ready, 1'b1);

        // load, MEM_LAT=3: rdata valid only on last wait cycle, done at T+4
        b3.req_valid = 1'b1; b3.req_we = 1'b0; b3.req_bmt = BMT_D;
        b3.req_addr = 64'h100; b3.mem_rdata = 64'h0123;
        step();
        b3.req_valid = 1'b0;
        chkb("ld_rd1", b3.mem_rd, 1'b1);
        chk ("ld_addr", b3.mem_addr, 64'h100);
        step();
        chkb("ld_rd2", b3.mem_rd, 1'b1);
        chkb("ld_early_done", b3.done_valid, 1'b0);
        step();
        b3.mem_rdata = 64'hDEADBEEF00000001;
        chkb("ld_rd3", b3.mem_rd, 1'b1);
        step();
        b3.mem_rdata = 64'h1111;
        chkb("ld_done", b3.done_valid, 1'b1);
        chk ("ld_rdata", b3.done_rdata, 64'hDEADBEEF00000001);
        chkb("ld_rd_off", b3.mem_rd, 1'b0);
        step();
        chkb("ld_done_off", b3.done_valid, 1'b0);
        chk ("ld_rdata_off", b3.done_rdata, 64'd0);
        chkb("ld_idle", b3.req_ready, 1'b1);

        // sw then load with req_valid held throughout
        b1.mem_rdata = 64'hAAAAAAAAAAAAAAAA;
        req1(1'b1, BMT_W, 64'h200, 64'h12345678);
        chkb("b2b_ready0", b1.req_ready, 1'b1);
        step();
        req1(1'b0, BMT_D, 64'h300, 64'h0);
        chkb("b2b_busy1", b1.req_ready, 1'b0);
        chkb("b2b_rd1", b1.mem_rd, 1'b1);
        chk ("b2b_rd_addr1", b1.mem_addr, 64'h200);
        step();
        chkb("b2b_busy2", b1.req_ready, 1'b0);
        step();
        chk ("b2b_sw_wdata", b1.mem_wdata, 64'hAAAAAAAA12345678);
        chk ("b2b_sw_addr", b1.mem_addr, 64'h200);
        step();
        chkb("b2b_done1", b1.done_valid, 1'b1);
        chkb("b2b_busy4", b1.req_ready, 1'b0);
        b1.mem_rdata = 64'h5555555555555555;
        step();
        chkb("b2b_ready5", b1.req_ready, 1'b1);
        chkb("b2b_done_off", b1.done_valid, 1'b0);
        step();
        b1.req_valid = 1'b0;
        chkb("b2b_rd6", b1.mem_rd, 1'b1);
        chk ("b2b_rd_addr6", b1.mem_addr, 64'h300);
        step();
        chkb("b2b_done2", b1.done_valid, 1'b1);
        chk ("b2b_ld_rdata", b1.done_rdata, 64'h5555555555555555);
        step();
        chkb("b2b_idle", b1.req_ready, 1'b1);

        // sh aborted by reset during WR; then reset beats a simultaneous request
        b1.mem_rdata = 64'hAAAAAAAAAAAAAAAA;
        req1(1'b1, BMT_H, 64'h400, 64'hBEEF);
        step();
        b1.req_valid = 1'b0;
        step();
        step();
        chkb("sh_wr", b1.mem_wr, 1'b1);
        chk ("sh_wdata", b1.mem_wdata, 64'hAAAAAAAAAAAABEEF);
        reset = 1'b1;
        step();
        chkb("sh_abort_wr", b1.mem_wr, 1'b0);
        chkb("sh_abort_done", b1.done_valid, 1'b0);
        chkb("sh_abort_ready", b1.req_ready, 1'b1);
        chk ("sh_abort_addr", b1.mem_addr, 64'd0);
        req1(1'b1, BMT_D, 64'h500, 64'h77);
        step();
        chkb("rstprio_wr", b1.mem_wr, 1'b0);
        chkb("rstprio_ready", b1.req_ready, 1'b1);
        reset = 1'b0;
        b1.req_valid = 1'b0;
        step();
        chkb("rstprio_wr2", b1.mem_wr, 1'b0);
        chkb("rstprio_rd2", b1.mem_rd, 1'b0);
        chkb("rstprio_ready2", b1.req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
